program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/loader_pkg.sv | 25 ++
 rtl/program_loader_if.sv | 23 ++
 rtl/word_assembler.sv | 48 ++++
 rtl/program_loader.sv | 102 ++++++++++
 tb/tb_program_loader.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM states, stream framing
// constants and the write-address helper.
package loader_pkg;

   typedef enum logic [2:0] {
      HDR0  = 3'd0,
      HDR1  = 3'd1,
      DATA  = 3'd2,
      WRITE = 3'd3,
      CHK   = 3'd4,
      DONE  = 3'd5,
      ERR   = 3'd6
   } state_t;

   localparam int HDR_BYTES           = 2;   // big-endian word count
   localparam int CHK_BYTES           = 1;   // XOR of all data bytes
   localparam int BYTES_PER_WORD      = 4;
   localparam int DEPTH_WORDS_DEFAULT = 64;

   // Byte address of word idx; wraps modulo 2^32.
   function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
      return base + {14'd0, idx, 2'b00};
   endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream handshake plus instruction-memory write bus of the loader.
interface program_loader_if;

   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        memwrite;
   logic [31:0] dataadr;
   logic [31:0] writedata;

   // master: stream source / memory sink side
   modport master (
      output in_data, in_valid,
      input  in_ready, memwrite, dataadr, writedata
   );

   // slave: the loader itself
   modport slave (
      input  in_data, in_valid,
      output in_ready, memwrite, dataadr, writedata
   );

endinterface

// File: rtl/word_assembler.sv
// Packs accepted data bytes MSB-first into a 32-bit word, tracks the byte
// position inside the current word and keeps the running XOR checksum.
module word_assembler
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset_ni,
   input  logic        byte_en_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        last_byte_o,
   output logic [7:0]  csum_o
);

   logic [31:0] word_q, word_d;
   logic [1:0]  cnt_q,  cnt_d;
   logic [7:0]  csum_q, csum_d;

   // Shift in the new byte, advance the position, fold it into the checksum.
   always_comb begin
      word_d = word_q;
      cnt_d  = cnt_q;
      csum_d = csum_q;
      if (byte_en_i) begin
         word_d = {word_q[23:0], byte_i};
         cnt_d  = cnt_q + 2'd1;
         csum_d = csum_q ^ byte_i;
      end
   end

   // Register update; a low reset drops any partially assembled word.
   always_ff @(posedge clk) begin
      if (!reset_ni) begin
         word_q <= '0;
         cnt_q  <= '0;
         csum_q <= '0;
      end else begin
         word_q <= word_d;
         cnt_q  <= cnt_d;
         csum_q <= csum_d;
      end
   end

   assign word_o      = word_q;
   assign last_byte_o = (cnt_q == 2'(BYTES_PER_WORD - 1));
   assign csum_o      = csum_q;

endmodule

// File: rtl/program_loader.sv
// Loads a framed byte stream (count header, big-endian words, XOR checksum)
// into instruction memory and holds the processor in reset until the load
// has completed with a good checksum.
module program_loader
   import loader_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   program_loader_if.slave  bus,
   output logic             cpu_reset,
   output logic             done,
   output logic             error
);

   state_t      state_q, state_d;
   logic [15:0] count_q, count_d;
   logic [15:0] idx_q,   idx_d;

   logic        accept;
   logic        xfer;
   logic        asm_en;
   logic        last_byte;
   logic        memwrite;
   logic [31:0] word;
   logic [7:0]  csum;

   word_assembler u_asm (
      .clk        (clk),
      .reset_ni   (reset),
      .byte_en_i  (asm_en),
      .byte_i     (bus.in_data),
      .word_o     (word),
      .last_byte_o(last_byte),
      .csum_o     (csum)
   );

   // in_ready is forced low while reset is held so nothing is taken then.
   assign accept       = (state_q == HDR0) || (state_q == HDR1) ||
                         (state_q == DATA) || (state_q == CHK);
   assign bus.in_ready = accept && reset;
   assign xfer         = bus.in_valid && bus.in_ready;

   // Next-state logic: header capture, word assembly, write, checksum check.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      idx_d   = idx_q;
      asm_en  = 1'b0;
      case (state_q)
         HDR0: if (xfer) begin
            count_d = {bus.in_data, 8'h00};
            state_d = HDR1;
         end
         HDR1: if (xfer) begin
            count_d = {count_q[15:8], bus.in_data};
            if ({16'd0, count_d} > 32'(DEPTH_WORDS)) state_d = ERR;
            else if (count_d == 16'd0)               state_d = CHK;
            else                                     state_d = DATA;
         end
         DATA: if (xfer) begin
            asm_en = 1'b1;
            if (last_byte) state_d = WRITE;
         end
         WRITE: begin
            idx_d   = idx_q + 16'd1;
            state_d = (idx_q + 16'd1 == count_q) ? CHK : DATA;
         end
         CHK: if (xfer) begin
            state_d = (bus.in_data == csum) ? DONE : ERR;
         end
         DONE, ERR: ;
         default: state_d = ERR;
      endcase
   end

   // State register; a low reset abandons any load in progress.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= HDR0;
         count_q <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         idx_q   <= idx_d;
      end
   end

   // Write bus is quiet (all zeros) outside the single WRITE cycle.
   assign memwrite      = (state_q == WRITE);
   assign bus.memwrite  = memwrite;
   assign bus.dataadr   = memwrite ? word_addr(BASE_ADDR, idx_q) : 32'd0;
   assign bus.writedata = memwrite ? word : 32'd0;

   assign cpu_reset = (state_q != DONE);
   assign done      = (state_q == DONE);
   assign error     = (state_q == ERR);

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: fixed vector table, hand-built
// multi-cycle sequences and randomized streams against a stream-level model.
`timescale 1ns/1ps
module tb_program_loader;
   import loader_pkg::*;

   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam int          DEPTH = 64;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic cpu_reset, done, error;

   program_loader_if bus ();

   program_loader #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .cpu_reset(cpu_reset),
      .done     (done),
      .error    (error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] adr;
      logic [31:0] dat;
   } wr_t;

   typedef struct {
      int           len;
      logic [127:0] b;         // stream bytes, first byte in [127:120]
      int           n_wr;
      logic [31:0]  last_adr;
      logic [31:0]  last_dat;
      bit           ok;        // 1: done expected, 0: error expected
   } vec_t;

   int checks = 0;
   int errors = 0;

   // model expectations
   wr_t exp_wr[$];
   bit  exp_done, exp_err;
   int  exp_xfers;

   // observations of the last run
   wr_t got_wr[$];
   int  wr_cyc[$];
   int  xfer_cyc[$];
   int  done_cyc, cyc;
   int  bad_idle, bad_ready, bad_notready, bad_cpu;
   bit  timed_out;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   // Stream-level reference: parse header, words and checksum directly.
   task automatic model(input logic [7:0] s[$]);
      int n;
      logic [7:0]  x;
      logic [31:0] w;
      exp_wr.delete();
      n = int'({s[0], s[1]});
      if (n > DEPTH) begin
         exp_done = 1'b0; exp_err = 1'b1; exp_xfers = HDR_BYTES;
         return;
      end
      x = 8'h00;
      for (int k = 0; k < n; k++) begin
         w = {s[2+4*k], s[3+4*k], s[4+4*k], s[5+4*k]};
         x = x ^ s[2+4*k] ^ s[3+4*k] ^ s[4+4*k] ^ s[5+4*k];
         exp_wr.push_back('{BASE + 32'(4*k), w});
      end
      exp_xfers = HDR_BYTES + 4*n + CHK_BYTES;
      exp_done  = (s[2+4*n] == x);
      exp_err   = !exp_done;
   endtask

   // Reset for two edges with a valid byte offered, checking cleared outputs.
   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0; bus.in_valid = 1'b1; bus.in_data = 8'hA5;
      @(negedge clk);
      chk("rst.memwrite",  32'(bus.memwrite), 32'd0);
      chk("rst.dataadr",   bus.dataadr,       32'd0);
      chk("rst.writedata", bus.writedata,     32'd0);
      chk("rst.done",      32'(done),         32'd0);
      chk("rst.error",     32'(error),        32'd0);
      chk("rst.cpu_reset", 32'(cpu_reset),    32'd1);
      chk("rst.in_ready",  32'(bus.in_ready), 32'd0);
      @(negedge clk);
      reset = 1'b1; bus.in_valid = 1'b0;
   endtask

   // Drive a stream with random valid gaps, observing every cycle.
   task automatic run(input logic [7:0] s[$], input int gap_pct, input int stop_wr);
      int i = 0;
      int budget = 20*s.size() + 50;
      int tail = -1;
      got_wr.delete(); wr_cyc.delete(); xfer_cyc.delete();
      done_cyc = -1; cyc = 0; timed_out = 1'b0;
      bad_idle = 0; bad_ready = 0; bad_notready = 0; bad_cpu = 0;
      forever begin
         @(negedge clk);
         if (bus.memwrite) begin
            got_wr.push_back('{bus.dataadr, bus.writedata});
            wr_cyc.push_back(cyc);
         end else if (bus.dataadr != 32'd0 || bus.writedata != 32'd0) bad_idle++;
         if ((bus.memwrite || done || error) && bus.in_ready) bad_ready++;
         if (!bus.memwrite && !done && !error && !bus.in_ready) bad_notready++;
         if (cpu_reset !== !done) bad_cpu++;
         if (done && done_cyc < 0) done_cyc = cyc;
         if (stop_wr > 0 && got_wr.size() == stop_wr) break;
         if (tail < 0 && (done || error)) tail = 4;
         if (tail == 0) break;
         if (tail > 0) tail--;
         if (cyc >= budget) begin timed_out = 1'b1; break; end
         if (i < s.size()) begin
            if ($urandom_range(99) >= 32'(gap_pct)) begin
               bus.in_valid = 1'b1; bus.in_data = s[i];
            end else begin
               bus.in_valid = 1'b0; bus.in_data = 8'($urandom);
            end
         end else begin
            bus.in_valid = 1'($urandom_range(1)); bus.in_data = 8'($urandom);
         end
         if (bus.in_valid && bus.in_ready) begin
            xfer_cyc.push_back(cyc);
            i++;
         end
         cyc++;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic verify(input string tag);
      chk({tag, ".timeout"}, 32'(timed_out), 32'd0);
      chk({tag, ".nwr"}, 32'(got_wr.size()), 32'(exp_wr.size()));
      for (int j = 0; j < got_wr.size() && j < exp_wr.size(); j++) begin
         chk({tag, ".adr"}, got_wr[j].adr, exp_wr[j].adr);
         chk({tag, ".dat"}, got_wr[j].dat, exp_wr[j].dat);
         if (4*j + 5 < xfer_cyc.size())
            chk({tag, ".wr_lat"}, 32'(wr_cyc[j]), 32'(xfer_cyc[4*j+5] + 1));
      end
      chk({tag, ".xfers"},     32'(xfer_cyc.size()), 32'(exp_xfers));
      chk({tag, ".done"},      32'(done),            32'(exp_done));
      chk({tag, ".error"},     32'(error),           32'(exp_err));
      chk({tag, ".cpu_reset"}, 32'(cpu_reset),       32'(!exp_done));
      if (exp_done && xfer_cyc.size() > 0)
         chk({tag, ".done_lat"}, 32'(done_cyc), 32'(xfer_cyc[xfer_cyc.size()-1] + 1));
      chk({tag, ".idle_bus"},  32'(bad_idle),     32'd0);
      chk({tag, ".ready_off"}, 32'(bad_ready),    32'd0);
      chk({tag, ".ready_on"},  32'(bad_notready), 32'd0);
      chk({tag, ".cpu_rst"},   32'(bad_cpu),      32'd0);
      $display("txn %s: bytes_in=%0d writes=%0d done=%0b error=%0b cycles=%0d",
               tag, xfer_cyc.size(), got_wr.size(), done, error, cyc);
   endtask

   // Build a well-formed stream of n random words; optionally corrupt checksum.
   task automatic make_stream(input int n, input bit bad_sum, output logic [7:0] s[$]);
      logic [7:0] x, b;
      s.delete();
      s.push_back(8'(n >> 8));
      s.push_back(8'(n));
      x = 8'h00;
      for (int k = 0; k < 4*n; k++) begin
         b = 8'($urandom);
         s.push_back(b);
         x ^= b;
      end
      if (bad_sum) x ^= 8'(1 << $urandom_range(7));
      s.push_back(x);
   endtask

   vec_t       vt[8];
   logic [7:0] s[$];
   int         n_rand;

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;

      vt[0] = '{7,  {56'h00_01_20_02_00_05_27, 72'h0},                 1, 32'd0, 32'h2002_0005, 1'b1};
      vt[1] = '{6,  {48'h00_41_DE_AD_BE_EF, 80'h0},                    0, 32'd0, 32'd0,         1'b0};
      vt[2] = '{11, {88'h00_02_11223344_55667788_89, 40'h0},           2, 32'd4, 32'h5566_7788, 1'b0};
      vt[3] = '{3,  {24'h00_00_00, 104'h0},                            0, 32'd0, 32'd0,         1'b1};
      vt[4] = '{3,  {24'h00_00_5A, 104'h0},                            0, 32'd0, 32'd0,         1'b0};
      vt[5] = '{4,  {32'h01_00_11_22, 96'h0},                          0, 32'd0, 32'd0,         1'b0};
      vt[6] = '{4,  {32'hFF_FF_00_00, 96'h0},                          0, 32'd0, 32'd0,         1'b0};
      vt[7] = '{7,  {56'h00_01_80_00_00_01_81, 72'h0},                 1, 32'd0, 32'h8000_0001, 1'b1};

      // Table-driven vectors, continuous valid.
      for (int v = 0; v < 8; v++) begin
         s.delete();
         for (int k = 0; k < vt[v].len; k++) s.push_back(vt[v].b[127-8*k -: 8]);
         model(s);
         do_reset();
         run(s, 0, 0);
         verify($sformatf("vec%0d", v));
         chk("vec.nwr",   32'(got_wr.size()), 32'(vt[v].n_wr));
         chk("vec.done",  32'(done),          32'(vt[v].ok));
         chk("vec.error", 32'(error),         32'(!vt[v].ok));
         if (vt[v].n_wr > 0 && got_wr.size() > 0) begin
            chk("vec.last_adr", got_wr[got_wr.size()-1].adr, vt[v].last_adr);
            chk("vec.last_dat", got_wr[got_wr.size()-1].dat, vt[v].last_dat);
         end
      end

      // Empty program back-to-back: done follows the third byte directly.
      s.delete(); s.push_back(8'h00); s.push_back(8'h00); s.push_back(8'h00);
      model(s); do_reset(); run(s, 0, 0);
      verify("empty");
      if (xfer_cyc.size() > 0) chk("empty.done_from_hdr", 32'(done_cyc - xfer_cyc[0]), 32'd3);

      // N=3 with valid held high: ready drops only in WRITE, nothing lost.
      make_stream(3, 1'b0, s); model(s); do_reset(); run(s, 0, 0);
      verify("n3_cont");

      // Largest accepted load with stalls.
      make_stream(DEPTH, 1'b0, s); model(s); do_reset(); run(s, 25, 0);
      verify("n_max");

      // Reset after the second write of an N=3 load, then a fresh N=1 load.
      make_stream(3, 1'b0, s); model(s); do_reset(); run(s, 0, 2);
      chk("mid.timeout", 32'(timed_out), 32'd0);
      chk("mid.nwr",     32'(got_wr.size()), 32'd2);
      do_reset();
      make_stream(1, 1'b0, s); model(s); run(s, 10, 0);
      verify("after_mid");

      // Randomized streams against the model.
      for (int t = 0; t < 15; t++) begin
         if ($urandom_range(3) == 0) n_rand = int'($urandom_range(DEPTH + 2, DEPTH - 2));
         else                        n_rand = int'($urandom_range(6));
         make_stream(n_rand, $urandom_range(3) == 0, s);
         model(s);
         do_reset();
         run(s, int'($urandom_range(60)), 0);
         verify($sformatf("rnd%0d_n%0d", t, n_rand));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
